// File: rtl/np_key_pkg.sv
// Shared definitions for the network-path key lookup blocks.
//   KEY_W     width of a key returned by keymem
//   KEY_ID_W  width of a key id
//   key_state_e  control states of the keymem lookup arbiter
package np_key_pkg;
  localparam int KEY_W    = 256;
  localparam int KEY_ID_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_GAP   = 2'd3
  } key_state_e;
endpackage

// File: rtl/keymem_arbiter_rr_arbiter.sv
// Combinational round-robin pick.
//   req      request vector, one bit per requester
//   ptr      index of the most recently granted requester
//   gnt_idx  first set index strictly after ptr (wrapping modulo N)
//   gnt_vld  high when any request bit is set
module rr_arbiter
  import np_key_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    gnt_idx  = '0;
    gnt_vld  = 1'b0;
    cand     = 32'd0;
    cand_idx = '0;
    for (int k = N; k >= 1; k--) begin
      cand     = (32'(ptr) + 32'(k)) % 32'(N);
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        gnt_idx = cand_idx;
        gnt_vld = 1'b1;
      end else begin
        gnt_idx = gnt_idx;
        gnt_vld = gnt_vld;
      end
    end
  end

endmodule

// File: rtl/keymem_arbiter.sv
// Shares one keymem lookup port between NUM_REQ network-path requesters.
// Round-robin grant, one lookup outstanding, timeout abort with error pulse.
//   clk156, areset_clk156       clock and asynchronous active-high reset
//   req_key_req/req_key_id      per-requester level request and key id
//   req_key_ack/req_key_err     one-cycle completion / error pulse to the winner
//   req_key                     shared key bus, qualified by req_key_ack
//   key_req/key_id/key_ack/key  port towards keymem_top
//   busy                        high whenever not IDLE
//   timeout_cnt                 saturating count of timed-out lookups
module keymem_arbiter
  import np_key_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TCNT_W         = 16
) (
  input  logic                        clk156,
  input  logic                        areset_clk156,
  input  logic [NUM_REQ-1:0]          req_key_req,
  input  logic [KEY_ID_W*NUM_REQ-1:0] req_key_id,
  output logic [NUM_REQ-1:0]          req_key_ack,
  output logic [NUM_REQ-1:0]          req_key_err,
  output logic [KEY_W-1:0]            req_key,
  output logic                        key_req,
  output logic [KEY_ID_W-1:0]         key_id,
  input  logic                        key_ack,
  input  logic [KEY_W-1:0]            key,
  output logic                        busy,
  output logic [TCNT_W-1:0]           timeout_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IDX_W-1:0]   RR_INIT  = IDX_W'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  key_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [KEY_ID_W-1:0] key_id_q, key_id_d;
  logic                key_req_q, key_req_d;
  logic [KEY_W-1:0]    req_key_q, req_key_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic                busy_q, busy_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_vld;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req_key_req),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // Next-state and registered-output computation for the lookup FSM.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    tmr_d     = tmr_q;
    key_id_d  = key_id_q;
    key_req_d = 1'b0;
    req_key_d = req_key_q;
    ack_d     = '0;
    err_d     = '0;
    tcnt_d    = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gidx_d    = pick_idx;
          ptr_d     = pick_idx;
          key_id_d  = req_key_id[KEY_ID_W*pick_idx +: KEY_ID_W];
          tmr_d     = '0;
          key_req_d = 1'b1;
          state_d   = ST_ISSUE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // key_ack takes precedence over the terminal timeout count.
        if (key_ack) begin
          req_key_d = key;
          ack_d     = ONE_HOT0 << gidx_q;
          state_d   = ST_RESP;
        end else if (tmr_q == TMR_LAST) begin
          req_key_d = '0;
          ack_d     = ONE_HOT0 << gidx_q;
          err_d     = ONE_HOT0 << gidx_q;
          if (tcnt_q != {TCNT_W{1'b1}}) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end else begin
            tcnt_d = tcnt_q;
          end
          state_d   = ST_RESP;
        end else begin
          tmr_d     = tmr_q + TMR_W'(1);
          key_req_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_RESP: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any lookup in flight.
  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      state_q   <= ST_IDLE;
      ptr_q     <= RR_INIT;
      gidx_q    <= '0;
      tmr_q     <= '0;
      key_id_q  <= '0;
      key_req_q <= 1'b0;
      req_key_q <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      tmr_q     <= tmr_d;
      key_id_q  <= key_id_d;
      key_req_q <= key_req_d;
      req_key_q <= req_key_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign req_key_ack = ack_q;
  assign req_key_err = err_q;
  assign req_key     = req_key_q;
  assign key_req     = key_req_q;
  assign key_id      = key_id_q;
  assign busy        = busy_q;
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_keymem_arbiter.sv
// Self-checking bench for keymem_arbiter: directed scenarios plus a randomized
// phase checked against a round-robin reference model.
module tb_keymem_arbiter;

  logic          clk;
  logic          areset;
  logic [3:0]    req_key_req;
  logic [127:0]  req_key_id;
  logic [3:0]    req_key_ack;
  logic [3:0]    req_key_err;
  logic [255:0]  req_key;
  logic          key_req;
  logic [31:0]   key_id;
  logic          key_ack;
  logic [255:0]  key;
  logic          busy;
  logic [15:0]   timeout_cnt;

  // Small instance for counter saturation: 2 requesters, short timeout, 2-bit counter.
  logic          s_rst;
  logic [1:0]    s_req;
  logic [63:0]   s_id;
  logic [1:0]    s_ack_o;
  logic [1:0]    s_err_o;
  logic [255:0]  s_rkey;
  logic          s_key_req;
  logic [31:0]   s_key_id;
  logic          s_key_ack;
  logic [255:0]  s_key;
  logic          s_busy;
  logic [1:0]    s_tcnt;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] ids [4];
  int mp;        // model: last granted index
  int tmodel;    // model: timeout count

  keymem_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(1024), .TCNT_W(16)) dut (
    .clk156        (clk),
    .areset_clk156 (areset),
    .req_key_req   (req_key_req),
    .req_key_id    (req_key_id),
    .req_key_ack   (req_key_ack),
    .req_key_err   (req_key_err),
    .req_key       (req_key),
    .key_req       (key_req),
    .key_id        (key_id),
    .key_ack       (key_ack),
    .key           (key),
    .busy          (busy),
    .timeout_cnt   (timeout_cnt)
  );

  keymem_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(4), .TCNT_W(2)) dut_sat (
    .clk156        (clk),
    .areset_clk156 (s_rst),
    .req_key_req   (s_req),
    .req_key_id    (s_id),
    .req_key_ack   (s_ack_o),
    .req_key_err   (s_err_o),
    .req_key       (s_rkey),
    .key_req       (s_key_req),
    .key_id        (s_key_id),
    .key_ack       (s_key_ack),
    .key           (s_key),
    .busy          (s_busy),
    .timeout_cnt   (s_tcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input int i, input logic [31:0] v);
    ids[i] = v;
    req_key_id[32*i +: 32] = v;
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
    mp = 3;
    tmodel = 0;
  endtask

  // Wait (bounded) until key_req is seen; n = negedges stepped.
  task automatic wait_req(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (key_req !== 1'b1 && n < 100);
    chk("key_req_seen", {255'd0, key_req}, 256'd1);
  endtask

  // One served lookup: keymem acks lat cycles after the first key_req cycle.
  task automatic lookup(input int lat, input int exp_g, input logic [255:0] k, output int n);
    logic [31:0] id0;
    bit          hold_ok;
    wait_req(n);
    id0 = key_id;
    chk("grant_key_id", {224'd0, key_id}, {224'd0, ids[exp_g]});
    hold_ok = 1'b1;
    for (int c = 0; c < lat; c++) begin
      for (int j = 0; j < 4; j++) begin
        if (j != exp_g) set_id(j, $urandom);
      end
      step();
      if (key_req !== 1'b1 || key_id !== id0 || busy !== 1'b1) hold_ok = 1'b0;
    end
    key_ack = 1'b1;
    key = k;
    step();
    key_ack = 1'b0;
    key = rand_key();
    chk("issue_hold", {255'd0, hold_ok}, 256'd1);
    chk("ack_vector", {252'd0, req_key_ack}, 256'd1 << exp_g);
    chk("err_vector", {252'd0, req_key_err}, 256'd0);
    chk("req_key", req_key, k);
    chk("timeout_cnt", {240'd0, timeout_cnt}, 256'(tmodel));
    req_key_req[exp_g] = 1'b0;
    mp = exp_g;
  endtask

  initial begin
    int n;
    int cnt;
    int nt;
    bit quiet;
    logic [255:0] k;
    logic [3:0] r;
    int order [5];
    order = '{0, 1, 2, 3, 0};

    areset = 1'b1;
    req_key_req = 4'b0000;
    req_key_id = '0;
    key_ack = 1'b0;
    key = '0;
    s_rst = 1'b1;
    s_req = 2'b01;
    s_id = 64'h0000_0B0B_0000_0A0A;
    s_key_ack = 1'b0;
    s_key = '0;
    for (int i = 0; i < 4; i++) ids[i] = 32'd0;
    step();
    step();

    // Reset state
    chk("rst_key_req", {255'd0, key_req}, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_ack", {252'd0, req_key_ack}, 256'd0);
    chk("rst_err", {252'd0, req_key_err}, 256'd0);
    chk("rst_tcnt", {240'd0, timeout_cnt}, 256'd0);
    chk("rst_req_key", req_key, 256'd0);
    chk("rst_key_id", {224'd0, key_id}, 256'd0);
    areset = 1'b0;
    mp = 3;
    tmodel = 0;

    // Single lookup from requester 0
    set_id(0, 32'h0000_0011);
    req_key_req = 4'b0001;
    lookup(3, 0, {8{32'hA5A5_A5A5}}, n);
    chk("issue_latency", 256'(n), 256'd1);
    step();
    chk("gap_busy", {255'd0, busy}, 256'd1);
    chk("gap_ack", {252'd0, req_key_ack}, 256'd0);
    step();
    chk("idle_busy", {255'd0, busy}, 256'd0);

    // Fairness with all four requesters active
    do_reset();
    for (int i = 0; i < 4; i++) set_id(i, 32'h10 + 32'(i));
    req_key_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      lookup($urandom_range(0, 4), order[i], rand_key(), n);
      step();
      req_key_req[order[i]] = 1'b1;
      set_id(order[i], 32'h10 + 32'(order[i]));
      for (int j = 0; j < 4; j++) set_id(j, 32'h10 + 32'(j));
    end
    req_key_req = 4'b0000;
    repeat (4) step();

    // Timeout: keymem never acks
    set_id(2, 32'h0000_0022);
    req_key_req = 4'b0100;
    wait_req(n);
    chk("to_key_id", {224'd0, key_id}, 256'h22);
    cnt = 0;
    while (key_req === 1'b1 && cnt < 1100) begin
      cnt++;
      step();
    end
    tmodel = 1;
    chk("to_key_req_cycles", 256'(cnt), 256'd1024);
    chk("to_ack", {252'd0, req_key_ack}, 256'h4);
    chk("to_err", {252'd0, req_key_err}, 256'h4);
    chk("to_req_key", req_key, 256'd0);
    chk("to_tcnt", {240'd0, timeout_cnt}, 256'd1);
    req_key_req = 4'b0000;
    mp = 2;
    repeat (4) step();
    key_ack = 1'b1;
    key = rand_key();
    step();
    key_ack = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      if (req_key_ack !== 4'b0000 || req_key_err !== 4'b0000 || req_key !== 256'd0 ||
          key_req !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("late_ack_ignored", {255'd0, quiet}, 256'd1);
    chk("late_ack_tcnt", {240'd0, timeout_cnt}, 256'd1);

    // key_ack in the terminal timeout cycle: normal completion
    set_id(1, 32'h0000_0055);
    req_key_req = 4'b0010;
    lookup(1023, 1, rand_key(), n);
    repeat (3) step();

    // Asynchronous reset in the middle of ISSUE
    set_id(0, 32'h0000_00A0);
    set_id(2, 32'h0000_00A2);
    req_key_req = 4'b0100;
    wait_req(n);
    step();
    req_key_req = 4'b0101;
    step();
    areset = 1'b1;
    #1;
    chk("arst_key_req", {255'd0, key_req}, 256'd0);
    chk("arst_busy", {255'd0, busy}, 256'd0);
    chk("arst_ack", {252'd0, req_key_ack}, 256'd0);
    chk("arst_tcnt", {240'd0, timeout_cnt}, 256'd0);
    tmodel = 0;
    step();
    areset = 1'b0;
    mp = 3;
    lookup(2, 0, rand_key(), n);
    req_key_req = 4'b0000;
    repeat (3) step();

    // Randomized lookups against the round-robin model
    for (int it = 0; it < 24; it++) begin
      r = 4'($urandom_range(1, 15));
      for (int j = 0; j < 4; j++) set_id(j, $urandom);
      req_key_req = r;
      k = rand_key();
      lookup($urandom_range(0, 6), pick(r, mp), k, n);
      req_key_req = 4'b0000;
      step();
    end
    repeat (3) step();

    // Saturation of a 2-bit timeout counter
    s_rst = 1'b0;
    nt = 0;
    cnt = 0;
    while (nt < 6 && cnt < 200) begin
      step();
      cnt++;
      if (s_err_o !== 2'b00) begin
        nt++;
        chk("sat_err", {254'd0, s_err_o}, 256'd1);
        chk("sat_cnt", {254'd0, s_tcnt}, 256'((nt > 3) ? 3 : nt));
      end
    end
    chk("sat_timeouts_seen", 256'(nt), 256'd6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
